apb_ram_ws: RTL and testbench
=============================

Name: apb_ram_ws

Overview:
- Parametrised APB4 slave RAM; next generation of the team's fixed 32x32 APB RAM slave.
- Adds configurable data width and depth, byte-addressed word access and byte-lane write strobes (pstrb).
- Adds programmable wait states, misalignment and out-of-range error detection, and a defined abort on a dropped psel.
- Sits on the APB peripheral bus behind the bridge as scratch/config storage.

Parameters:
- ADDR_WIDTH, 32: width of paddr (byte address).
- DATA_WIDTH, 32: data width; legal values 8, 16, 32 or 64.
- DEPTH, 64: number of DATA_WIDTH words; need not be a power of 2.
- WAIT_STATES, 0: extra pready-low cycles inserted in the ACCESS phase (0..15).

Ports:
- pclk  in  1  APB clock; all logic on its rising edge.
- preset  in  1  asynchronous, active-high reset.
- psel  in  1  slave select.
- penable  in  1  ACCESS-phase indicator.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte-lane write enables; ignored on reads.
- prdata  out  DATA_WIDTH  read data; valid while pready=1 on a read.
- pready  out  1  transfer complete.
- pslverr  out  1  error; valid only while pready=1.

Behaviour:
- Reset (preset=1, asynchronous): state=IDLE, wait counter=0, prdata=0, pready=0, pslverr=0, all memory words cleared to 0. Reset mid-transfer abandons the transfer; no partial write.
- Definitions:
  - LSB = log2(DATA_WIDTH/8).
  - idx = paddr >> LSB.
  - misaligned = paddr[LSB-1:0] != 0; never true when DATA_WIDTH=8.
  - oor = idx >= DEPTH; comparison uses the full ADDR_WIDTH-LSB bits, so there is no wrap-around.
  - err = misaligned | oor.
- IDLE:
  - pready=0, pslverr=0.
  - Cycles with psel=1, penable=0 (SETUP) cause no action.
  - At an edge with psel=1 and penable=1: if WAIT_STATES=0, execute and go to RESP; else load counter=WAIT_STATES and go to WAIT.
- WAIT:
  - Counter decrements each edge; at an edge where counter=1, execute and go to RESP.
  - If psel=0 or penable=0 at any edge: go to IDLE, no write, outputs unchanged (protocol-violation abort).
- Execute, on the edge entering RESP:
  - Write, err=0: for each lane b with pstrb[b]=1, set mem[idx] byte b = pwdata byte b. pstrb=0 is a legal no-op write.
  - Read, err=0: prdata <= mem[idx].
  - err=1: no memory change; prdata <= 0, never X; pslverr <= 1.
  - pready <= 1.
- RESP:
  - pready=1 for exactly one cycle; then pready=0, pslverr=0, go to IDLE.
  - prdata holds its value until the next read completes.
- Latency:
  - pready rises WAIT_STATES+1 cycles after the first ACCESS cycle, so the ACCESS phase lasts WAIT_STATES+2 cycles.
  - Back-to-back transfers (SETUP directly after RESP) are supported at full rate.
- Paddr, pwrite, pwdata and pstrb are sampled at the execute edge. The master must hold them stable throughout ACCESS, per APB.
- Read-after-write to the same word returns the new data on the next transfer; there is no bypass requirement within one transfer.

Decomposition:
- Package apb_ram_pkg:
  - state enum apb_ram_state_e {IDLE, WAIT, RESP}.
  - function clog2-based lsb_bits(DATA_WIDTH).
  - localparam for maximum WAIT_STATES (15).
- Sub-module apb_ram_bytemem:
  - DEPTH x DATA_WIDTH array with per-byte write enable, synchronous write, registered read, asynchronous clear.
  - The FSM, address decode and error logic stay in apb_ram_ws.

Test Plan:
- Reset, then read addr 0x0 -> pready after 1 ACCESS cycle (WAIT_STATES=0), prdata=0x00000000, pslverr=0.
- Write 0xDEADBEEF to 0x10 with pstrb=4'b1111, then write 0x11223344 to 0x10 with pstrb=4'b0101, then read 0x10 -> 0xDE22BE44, pslverr=0.
- Read 0x100 (DEPTH=64, idx=64) -> pslverr=1, prdata=0; write to 0x101 (misaligned) -> pslverr=1, then read 0x100 aligned-valid neighbour 0xFC returns its previous contents.
- WAIT_STATES=3: write 0xA5A5A5A5 to 0x4 -> pready low for the first 4 ACCESS cycles, high in the 5th; read back matches.
- WAIT_STATES=3: drop psel after 1 ACCESS cycle of a write to 0x8 -> no pready pulse, state IDLE; read 0x8 -> 0.
- Assert preset asynchronously mid-WAIT -> pready/pslverr/prdata go to 0 immediately, before the next edge; memory reads 0 afterwards; back-to-back write/read pairs after reset succeed at full rate.

Source files
------------

// File: rtl/apb_ram_pkg.sv
// apb_ram_pkg: shared state encoding and sizing helpers for the APB RAM slave
package apb_ram_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_ram_state_e;
  localparam int MAX_WAIT_STATES = 15;
  function automatic int lsb_bits(int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/apb_ram_ws_if.sv
// apb_ram_ws_if: APB4 bus bundle between the bridge and the RAM slave
interface apb_ram_ws_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;
  modport master(output psel, penable, pwrite, paddr, pwdata, pstrb, input prdata, pready, pslverr);
  modport slave(input psel, penable, pwrite, paddr, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_ram_bytemem.sv
// apb_ram_bytemem: byte-lane writable word array with registered, clearable read port
module apb_ram_bytemem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int AW         = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    re,
  input  logic                    rclr,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we)
        for (int b = 0; b < DATA_WIDTH / 8; b++)
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      // rdata holds between reads; an errored access forces it to zero
      rdata <= rclr ? '0 : re ? mem[addr] : rdata;
    end
endmodule

// File: rtl/apb_ram_ws.sv
// apb_ram_ws: parametrised APB4 RAM slave with byte strobes, wait states and error response
module apb_ram_ws
  import apb_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input logic         pclk,
  input logic         preset,
  apb_ram_ws_if.slave bus
);
  localparam int LSB = lsb_bits(DATA_WIDTH);
  localparam int AW  = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(MAX_WAIT_STATES + 1);
  apb_ram_state_e        state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  access, err, go, pready_q, pslverr_q;
  always_comb begin
    idx    = bus.paddr >> LSB;
    access = bus.psel & bus.penable;
    // full-width compare so high address bits can never alias into the array
    err    = (|(bus.paddr & ADDR_WIDTH'((1 << LSB) - 1))) | (idx >= ADDR_WIDTH'(DEPTH));
    go     = access & (state == WAIT ? cnt == CW'(1) : state == IDLE && WAIT_STATES == 0);
  end
  always_ff @(posedge pclk or posedge preset)
    if (preset) begin
      state     <= IDLE;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else
      case (state)
        IDLE: if (access) begin
          state     <= go ? RESP : WAIT;
          cnt       <= CW'(WAIT_STATES);
          pready_q  <= go;
          pslverr_q <= go & err;
        end
        WAIT: begin
          cnt       <= cnt - CW'(1);
          state     <= !access ? IDLE : go ? RESP : WAIT;
          pready_q  <= go;
          pslverr_q <= go & err;
        end
        default: begin
          state     <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
      endcase
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  apb_ram_bytemem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk  (pclk),
    .rst  (preset),
    .we   (go & bus.pwrite & ~err),
    .re   (go & ~bus.pwrite & ~err),
    .rclr (go & err),
    .addr (idx[AW-1:0]),
    .be   (bus.pstrb),
    .wdata(bus.pwdata),
    .rdata(bus.prdata)
  );
endmodule

// File: tb/tb_apb_ram_ws.sv
// tb_apb_ram_ws: randomized APB traffic on a 0- and a 3-wait-state RAM against a word-array model
module tb_apb_ram_ws;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mdl [2][64];
  logic [31:0] lastrd [2];
  logic [31:0] rd;
  always #5 clk = ~clk;
  apb_ram_ws_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  apb_ram_ws_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();
  assign b0.psel = psel[0];
  assign b3.psel = psel[1];
  assign b0.penable = penable;
  assign b3.penable = penable;
  assign b0.pwrite = pwrite;
  assign b3.pwrite = pwrite;
  assign b0.paddr = paddr;
  assign b3.paddr = paddr;
  assign b0.pwdata = pwdata;
  assign b3.pwdata = pwdata;
  assign b0.pstrb = pstrb;
  assign b3.pstrb = pstrb;
  apb_ram_ws #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u0 (.pclk(clk), .preset(rst), .bus(b0));
  apb_ram_ws #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u3 (.pclk(clk), .preset(rst), .bus(b3));
  function automatic logic rdy(int d);
    return d != 0 ? b3.pready : b0.pready;
  endfunction
  function automatic logic perr(int d);
    return d != 0 ? b3.pslverr : b0.pslverr;
  endfunction
  function automatic logic [31:0] prd(int d);
    return d != 0 ? b3.prdata : b0.prdata;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      lastrd[d] = '0;
      for (int i = 0; i < 64; i++) mdl[d][i] = '0;
    end
  endtask
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] r, output logic er, output int lat);
    @(posedge clk); #1;
    psel = d != 0 ? 2'b10 : 2'b01;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = wd;
    pstrb = st;
    check("setup_rdy", 64'(rdy(d)), 64'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rdy(d) && lat < 40);
    r = prd(d);
    er = perr(d);
  endtask
  task automatic txn(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] r);
    logic e, er;
    int   lat, i;
    e = a[1:0] != 2'b00 || (a >> 2) >= 32'd64;
    i = int'(a[7:2]);
    xfer(d, wr, a, wd, st, r, er, lat);
    check("latency", 64'(lat), 64'(d != 0 ? 4 : 1));
    check("pslverr", 64'(er), 64'(e));
    if (e) lastrd[d] = '0;
    else if (!wr) lastrd[d] = mdl[d][i];
    else for (int b = 0; b < 4; b++) if (st[b]) mdl[d][i][8*b +: 8] = wd[8*b +: 8];
    check("prdata", 64'(r), 64'(lastrd[d]));
  endtask
  task automatic idle();
    @(posedge clk); #1;
    psel = 2'b00;
    penable = 1'b0;
    check("idle_rdy", 64'(rdy(0) | rdy(1)), 64'd0);
  endtask
  initial begin
    rst = 1'b1;
    psel = 2'b00;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    pstrb = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("rst_rdy", 64'(rdy(d)), 64'd0);
      check("rst_err", 64'(perr(d)), 64'd0);
      check("rst_rdata", 64'(prd(d)), 64'd0);
    end
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd);
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd);
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    check("strb_merge", 64'(rd), 64'hDE22BE44);
    idle();
    txn(0, 1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, rd);
    txn(0, 1'b0, 32'h100, 32'h0, 4'h0, rd);
    txn(0, 1'b1, 32'h101, 32'h12345678, 4'hF, rd);
    txn(0, 1'b0, 32'hFC, 32'h0, 4'h0, rd);
    check("neighbour", 64'(rd), 64'hCAFEF00D);
    txn(0, 1'b0, 32'h4000_0010, 32'h0, 4'h0, rd);
    idle();
    txn(1, 1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, rd);
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, rd);
    check("ws_readback", 64'(rd), 64'hA5A5A5A5);
    idle();
    @(posedge clk); #1;
    psel = 2'b10;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 32'h8;
    pwdata = 32'h5A5A5A5A;
    pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 2'b00;
    penable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_rdy", 64'(rdy(1)), 64'd0);
    end
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, rd);
    check("abort_nowrite", 64'(rd), 64'd0);
    idle();
    for (int n = 0; n < 300; n++) begin
      int          d, kind;
      logic        wr;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      kind = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 63)) << 2;
      if (kind == 7) a = a | 32'($urandom_range(1, 3));
      else if (kind == 8) a = 32'h100 + (32'($urandom_range(0, 200)) << 2);
      else if (kind == 9) a = $urandom;
      txn(d, wr, a, $urandom, 4'($urandom), rd);
      if ($urandom_range(0, 1) == 0) idle();
    end
    idle();
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    @(posedge clk); #1;
    psel = 2'b10;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 32'h20;
    pwdata = 32'hFFFFFFFF;
    pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_rdy", 64'(rdy(1)), 64'd0);
    check("arst_err", 64'(perr(1)), 64'd0);
    check("arst_rdata3", 64'(prd(1)), 64'd0);
    check("arst_rdata0", 64'(prd(0)), 64'd0);
    @(posedge clk); #1;
    psel = 2'b00;
    penable = 1'b0;
    rst = 1'b0;
    clear_model();
    txn(1, 1'b0, 32'h20, 32'h0, 4'h0, rd);
    txn(1, 1'b0, 32'h4, 32'h0, 4'h0, rd);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    for (int n = 0; n < 20; n++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 63)) << 2;
      txn(d, 1'b1, a, $urandom, 4'hF, rd);
      txn(d, 1'b0, a, 32'h0, 4'h0, rd);
    end
    idle();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
